// File: rtl/mem_responder_if.sv
// Memory-port bundle between the memory controller (master) and the on-chip responder (slave).
// Strobes and addresses flow master->slave; registered read data and status flow back.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

interface mem_responder_if;
    logic                   mem_r_en;
    logic [`DATA_WIDTH-1:0] mem_r_addr;
    logic                   mem_w_en;
    logic [`DATA_WIDTH-1:0] mem_w_addr;
    logic [`DATA_WIDTH-1:0] mem_w_data;
    logic [`DATA_WIDTH-1:0] mem_r_data;
    logic                   o_ready;
    logic                   o_r_valid;
    logic                   o_err;

    modport master (
        output mem_r_en, mem_r_addr, mem_w_en, mem_w_addr, mem_w_data,
        input  mem_r_data, o_ready, o_r_valid, o_err
    );

    modport slave (
        input  mem_r_en, mem_r_addr, mem_w_en, mem_w_addr, mem_w_data,
        output mem_r_data, o_ready, o_r_valid, o_err
    );
endinterface

// File: rtl/mem_responder.sv
// On-chip word RAM responder: zeroes all words after reset, then serves reads (1-cycle, registered)
// and writes every cycle with no backpressure; write-first bypass on same-index read/write.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module mem_responder #(
    parameter int ADDR_BITS = 8
) (
    input logic           clk,
    input logic           rst,
    mem_responder_if.slave mem
);
    localparam int DW    = `DATA_WIDTH;
    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic {INIT, READY} state_t;

    state_t                 state_q;
    logic [ADDR_BITS-1:0]   cnt_q;
    logic [DW-1:0]          r_data_q;
    logic                   ready_q;
    logic                   r_valid_q;
    logic                   err_q;
    logic [DW-1:0]          ram_q [DEPTH];

    logic                   r_in_range;
    logic                   w_in_range;
    logic [ADDR_BITS-1:0]   r_idx;
    logic [ADDR_BITS-1:0]   w_idx;
    logic                   bypass;
    logic [DW-1:0]          r_word;

    assign r_in_range = (mem.mem_r_addr >> ADDR_BITS) == '0;
    assign w_in_range = (mem.mem_w_addr >> ADDR_BITS) == '0;
    assign r_idx      = mem.mem_r_addr[ADDR_BITS-1:0];
    assign w_idx      = mem.mem_w_addr[ADDR_BITS-1:0];
    // Same-index write in the same cycle wins over the stored word.
    assign bypass     = mem.mem_w_en && w_in_range && (w_idx == r_idx);
    assign r_word     = bypass ? mem.mem_w_data : ram_q[r_idx];

    // Storage has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            ram_q[cnt_q] <= '0;
        end else if (mem.mem_w_en && w_in_range) begin
            ram_q[w_idx] <= mem.mem_w_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            r_data_q  <= '0;
            ready_q   <= 1'b0;
            r_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    cnt_q     <= cnt_q + 1'b1;
                    r_valid_q <= 1'b0;
                    err_q     <= 1'b0;
                    if (cnt_q == ADDR_BITS'(DEPTH - 1)) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                    end
                end
                READY: begin
                    r_valid_q <= mem.mem_r_en;
                    err_q     <= (mem.mem_r_en && !r_in_range) ||
                                 (mem.mem_w_en && !w_in_range);
                    if (mem.mem_r_en) begin
                        r_data_q <= r_in_range ? r_word : '0;
                    end
                end
                default: state_q <= INIT;
            endcase
        end
    end

    assign mem.mem_r_data = r_data_q;
    assign mem.o_ready    = ready_q;
    assign mem.o_r_valid  = r_valid_q;
    assign mem.o_err      = err_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder (ADDR_BITS=4): clear sequence, reads/writes, bypass,
// out-of-range handling, back-to-back reads and mid-operation reset.
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_mem_responder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   edges;
    logic seen_vld;

    mem_responder_if bus();

    mem_responder #(.ADDR_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .mem (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r_en, input logic [15:0] r_addr,
                         input logic w_en, input logic [15:0] w_addr, input logic [15:0] w_data);
        bus.mem_r_en   = r_en;
        bus.mem_r_addr = r_addr;
        bus.mem_w_en   = w_en;
        bus.mem_w_addr = w_addr;
        bus.mem_w_data = w_data;
    endtask

    task automatic wait_clear(input string tag);
        edges    = 0;
        seen_vld = 1'b0;
        while (!bus.o_ready && edges < 40) begin
            tick();
            edges++;
            if (bus.o_r_valid || bus.o_err) seen_vld = 1'b1;
        end
        check({tag, "_clear_edges"}, edges, 16);
        check({tag, "_no_vld_in_init"}, seen_vld, 0);
    endtask

    initial begin
        drive(1'b1, 16'h0005, 1'b0, 16'h0, 16'h0);
        #12;
        check("rst_rdata", bus.mem_r_data, 0);
        check("rst_ready", bus.o_ready, 0);
        check("rst_rvld",  bus.o_r_valid, 0);
        check("rst_err",   bus.o_err, 0);

        @(posedge clk); #1;
        rst = 1'b0;
        wait_clear("init1");

        // First READY read of address 5
        tick();
        check("rd5_data", bus.mem_r_data, 16'h0000);
        check("rd5_vld",  bus.o_r_valid, 1);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        tick();
        check("idle_vld", bus.o_r_valid, 0);

        // Write then read address 3
        drive(1'b0, 16'h0, 1'b1, 16'h0003, 16'h1234);
        tick();
        drive(1'b1, 16'h0003, 1'b0, 16'h0, 16'h0);
        tick();
        check("rd3_data", bus.mem_r_data, 16'h1234);
        check("rd3_vld",  bus.o_r_valid, 1);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        tick();
        check("hold1_data", bus.mem_r_data, 16'h1234);
        check("hold1_vld",  bus.o_r_valid, 0);
        tick();
        check("hold2_data", bus.mem_r_data, 16'h1234);

        // Same-index bypass, then different-index read/write
        drive(1'b1, 16'h0007, 1'b1, 16'h0007, 16'h00AB);
        tick();
        check("bypass_data", bus.mem_r_data, 16'h00AB);
        drive(1'b1, 16'h0007, 1'b1, 16'h0002, 16'h0011);
        tick();
        check("diff_data", bus.mem_r_data, 16'h00AB);
        drive(1'b1, 16'h0002, 1'b0, 16'h0, 16'h0);
        tick();
        check("diff_wr2", bus.mem_r_data, 16'h0011);

        // Out-of-range write, word 3 untouched
        drive(1'b0, 16'h0, 1'b1, 16'h0013, 16'hBEEF);
        tick();
        check("oor_wr_err", bus.o_err, 1);
        check("oor_wr_vld", bus.o_r_valid, 0);
        drive(1'b1, 16'h0003, 1'b0, 16'h0, 16'h0);
        tick();
        check("oor_wr_err_clr", bus.o_err, 0);
        check("word3_kept", bus.mem_r_data, 16'h1234);
        drive(1'b1, 16'h0010, 1'b0, 16'h0, 16'h0);
        tick();
        check("oor_rd_data", bus.mem_r_data, 0);
        check("oor_rd_vld",  bus.o_r_valid, 1);
        check("oor_rd_err",  bus.o_err, 1);
        drive(1'b1, 16'h0020, 1'b1, 16'h0040, 16'h7777);
        tick();
        check("oor_both_err", bus.o_err, 1);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
        tick();
        check("oor_both_clr", bus.o_err, 0);

        // Back-to-back reads
        drive(1'b0, 16'h0, 1'b1, 16'h0001, 16'h0011); tick();
        drive(1'b0, 16'h0, 1'b1, 16'h0002, 16'h0022); tick();
        drive(1'b0, 16'h0, 1'b1, 16'h0003, 16'h0033); tick();
        drive(1'b1, 16'h0001, 1'b0, 16'h0, 16'h0); tick();
        check("b2b1_data", bus.mem_r_data, 16'h0011);
        check("b2b1_vld",  bus.o_r_valid, 1);
        drive(1'b1, 16'h0002, 1'b0, 16'h0, 16'h0); tick();
        check("b2b2_data", bus.mem_r_data, 16'h0022);
        check("b2b2_vld",  bus.o_r_valid, 1);
        drive(1'b1, 16'h0003, 1'b0, 16'h0, 16'h0); tick();
        check("b2b3_data", bus.mem_r_data, 16'h0033);
        check("b2b3_vld",  bus.o_r_valid, 1);
        drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0); tick();
        check("b2b_end_vld", bus.o_r_valid, 0);

        // Reset during READY
        drive(1'b0, 16'h0, 1'b1, 16'h0009, 16'h5555); tick();
        drive(1'b1, 16'h0009, 1'b0, 16'h0, 16'h0); tick();
        check("rd9_pre", bus.mem_r_data, 16'h5555);
        rst = 1'b1;
        #1;
        check("rst2_rdata", bus.mem_r_data, 0);
        check("rst2_ready", bus.o_ready, 0);
        check("rst2_rvld",  bus.o_r_valid, 0);
        tick();
        tick();
        rst = 1'b0;
        wait_clear("init2");
        tick();
        check("rd9_post", bus.mem_r_data, 0);
        check("rd9_post_vld", bus.o_r_valid, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
